// File: rtl/multicycle_adder.sv
// Multicycle adder: adds WIDTH-bit operands CHUNK bits per cycle behind a valid/ready handshake.
// Optional subtract mode is enabled by defining MULTICYCLE_ADDER_SUB_EN.
`timescale 1ns/1ps

module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             accept_s;
  logic             finish_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             run_carry_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             overflow_r;
  logic [WIDTH-1:0] b_eff_s;
  logic             cin_eff_s;
  logic [CHUNK-1:0] a_slice_s;
  logic [CHUNK-1:0] b_slice_s;
  logic [CHUNK:0]   chunk_sum_s;
  logic             ovf_s;

  // Effective operands: inversion logic exists only when subtraction is built in
`ifdef MULTICYCLE_ADDER_SUB_EN
  always_comb begin
    b_eff_s   = b;
    cin_eff_s = cin;
    if (sub) begin
      b_eff_s   = ~b;
      cin_eff_s = 1'b1;
    end else begin
      b_eff_s   = b;
      cin_eff_s = cin;
    end
  end
`else
  logic unused_sub_s;
  assign unused_sub_s = sub;

  // Effective operands pass straight through in add-only builds
  always_comb begin
    b_eff_s   = b;
    cin_eff_s = cin;
  end
`endif

  // One CHUNK-wide slice add selected by the step counter, plus final overflow test
  always_comb begin
    a_slice_s   = a_r[int'(cnt_r)*CHUNK +: CHUNK];
    b_slice_s   = b_r[int'(cnt_r)*CHUNK +: CHUNK];
    chunk_sum_s = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {{CHUNK{1'b0}}, run_carry_r};
    ovf_s       = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (chunk_sum_s[CHUNK-1] != a_r[WIDTH-1]);
  end

  // Next-state logic and handshake strobes
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s = 1'b1;
          state_s  = BUSY;
        end else begin
          state_s  = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == LAST_STEP) begin
          finish_s = 1'b1;
          state_s  = DONE;
        end else begin
          state_s  = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with handshake flags registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture, slice-by-slice result accumulation and step counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      run_carry_r <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (accept_s) begin
      cnt_r       <= {CNT_W{1'b0}};
      a_r         <= a;
      b_r         <= b_eff_s;
      run_carry_r <= cin_eff_s;
    end else if (state_r == BUSY) begin
      sum_r[int'(cnt_r)*CHUNK +: CHUNK] <= chunk_sum_s[CHUNK-1:0];
      run_carry_r <= chunk_sum_s[CHUNK];
      cnt_r       <= cnt_r + CNT_W'(1);
      if (finish_s) begin
        carry_r    <= chunk_sum_s[CHUNK];
        overflow_r <= ovf_s;
      end else begin
        carry_r    <= carry_r;
        overflow_r <= overflow_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign carry     = carry_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder: driver pushes model results, negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_multicycle_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int STEPS = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  res_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  multicycle_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: full-precision integer addition of the effective operands
  function automatic res_t model(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic c, logic s);
    logic [WIDTH-1:0] yb;
    logic             cb;
    logic [WIDTH:0]   full;
    res_t             r;
    yb = y;
    cb = c;
`ifdef MULTICYCLE_ADDER_SUB_EN
    if (s) begin
      yb = ~y;
      cb = 1'b1;
    end
`else
    if (s) cb = c;
`endif
    full    = {1'b0, x} + {1'b0, yb} + {{WIDTH{1'b0}}, cb};
    r.sum   = full[WIDTH-1:0];
    r.carry = full[WIDTH];
    r.ovf   = (x[WIDTH-1] == yb[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic scramble();
    a   = WIDTH'($urandom);
    b   = WIDTH'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // Monitor: every completed output handshake is matched against the queue head
  always @(negedge clk) begin : monitor
    res_t r;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got sum %0h with empty scoreboard", sum);
      end else begin
        r = exp_q.pop_front();
        check("sum", 32'(sum), 32'(r.sum));
        check("carry", 32'(carry), 32'(r.carry));
        check("overflow", 32'(overflow), 32'(r.ovf));
      end
    end
  end

  task automatic run_op(logic [WIDTH-1:0] xa, logic [WIDTH-1:0] xb, logic xc, logic xs, int hold);
    res_t e;
    int   n;
    @(posedge clk); #1;
    a = xa; b = xb; cin = xc; sub = xs;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    e = model(xa, xb, xc, xs);
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
    scramble();
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
      scramble();
    end
    check("latency", 32'(n), 32'(STEPS));
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_sum", 32'(sum), 32'(e.sum));
      check("hold_carry", 32'(carry), 32'(e.carry));
      check("hold_ovf", 32'(overflow), 32'(e.ovf));
      scramble();
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("idle_hold_sum", 32'(sum), 32'(e.sum));
  endtask

  task automatic reset_mid_op(logic [WIDTH-1:0] xa, logic [WIDTH-1:0] xb);
    @(posedge clk); #1;
    a = xa; b = xb; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    #1 reset = 1'b1;
    #1;
    check("init_in_ready", 32'(in_ready), 32'd1);
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_sum", 32'(sum), 32'd0);
    check("init_carry", 32'(carry), 32'd0);
    check("init_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 3);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h1234, 16'h0000, 1'b1, 1'b0, 1);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 2);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
    reset_mid_op(16'hABCD, 16'h1111);
    run_op(16'h4321, 16'h1234, 1'b1, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end
    @(posedge clk); #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
